// File: rtl/bsg_pkg.sv
// Shared definitions for the multi-channel bitstream generator: mode and
// state encodings plus the maximal-length LFSR tap table.
package bsg_pkg;

  typedef enum logic {
    MODE_UNARY = 1'b0,
    MODE_STOCH = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bit t-1 set for each tap t of a maximal-length polynomial of degree w.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/bsg_lfsr.sv
// Fibonacci LFSR with de Bruijn extension: the all-zero state is spliced in
// once per period so the sequence visits every WIDTH-bit value exactly once.
module bsg_lfsr
  import bsg_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_nxt
);

  localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q;
  logic             fb;

  // Inverting feedback when the low bits are zero turns 100..0 -> 0 -> 00..01.
  assign fb        = (^(state_q & TAPS)) ^ (state_q[WIDTH-2:0] == '0);
  assign value_nxt = {state_q[WIDTH-2:0], fb};
  assign value     = state_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= value_nxt;
    end
  end

endmodule

// File: rtl/multi_bitstream_gen.sv
// Converts CHANNELS binary values into correlated unary or stochastic
// bitstreams of 2^WIDTH beats, all channels sharing one sequence source.
module multi_bitstream_gen
  import bsg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int LFSR_SEED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic                      abort,
  output logic [CHANNELS-1:0]       bits_out,
  output logic                      bits_valid,
  input  logic                      bits_ready,
  output logic                      done
);

  localparam logic [WIDTH-1:0] SEED_W = LFSR_SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] K_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] K_LAST = {WIDTH{1'b1}};

  state_e                    state_q;
  mode_e                     mode_q;
  logic [CHANNELS*WIDTH-1:0] data_q;
  logic [WIDTH-1:0]          k_q;
  logic [CHANNELS-1:0]       bits_q;
  logic                      valid_q;
  logic                      done_q;

  logic [WIDTH-1:0]    k_nxt;
  logic [WIDTH-1:0]    lfsr_value;
  logic [WIDTH-1:0]    lfsr_next;
  logic [WIDTH-1:0]    src_first;
  logic [WIDTH-1:0]    src_next;
  logic                beat_acc;
  logic                leave_run;
  logic                lfsr_load;
  logic                lfsr_adv;
  logic [CHANNELS-1:0] cmp_first;
  logic [CHANNELS-1:0] cmp_next;

  assign k_nxt     = k_q + K_ONE;
  assign beat_acc  = (state_q == ST_RUN) && valid_q && bits_ready && !abort;
  assign leave_run = (state_q == ST_RUN) && (abort || (valid_q && bits_ready && done_q));

  // Holding the source at the seed while idle lets the first beat use its current value.
  assign lfsr_load = (state_q == ST_IDLE) || leave_run;
  assign lfsr_adv  = beat_acc && !done_q;

  assign src_first = (mode_e'(mode) == MODE_STOCH) ? lfsr_value : k_q;
  assign src_next  = (mode_q == MODE_STOCH) ? lfsr_next : k_nxt;

  bsg_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED_W)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .value     (lfsr_value),
    .value_nxt (lfsr_next)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign cmp_first[i] = data_in[i*WIDTH +: WIDTH] > src_first;
    assign cmp_next[i]  = data_q[i*WIDTH +: WIDTH] > src_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UNARY;
      data_q  <= '0;
      k_q     <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            state_q <= ST_RUN;
            mode_q  <= mode_e'(mode);
            data_q  <= data_in;
            k_q     <= '0;
            bits_q  <= cmp_first;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (leave_run) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end else if (beat_acc) begin
            k_q    <= k_nxt;
            bits_q <= cmp_next;
            done_q <= (k_nxt == K_LAST);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == ST_IDLE) && !rst;
  assign bits_out   = bits_q;
  assign bits_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_multi_bitstream_gen.sv
// Scoreboard bench for multi_bitstream_gen at WIDTH=4, CHANNELS=4, seed 1.
module tb_multi_bitstream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] data_in;
  logic        mode;
  logic        abort;
  logic [3:0]  bits_out;
  logic        bits_valid;
  logic        bits_ready;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Expected beat: {done, bits_out[3:0]}
  logic [4:0] sb_q[$];

  // Extended x^4+x^3+1 sequence from seed 1, worked out by hand.
  logic [3:0] stoch_seq [16] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd0};

  always #5 clk = ~clk;

  multi_bitstream_gen #(
    .WIDTH     (4),
    .CHANNELS  (4),
    .LFSR_SEED (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .mode       (mode),
    .abort      (abort),
    .bits_out   (bits_out),
    .bits_valid (bits_valid),
    .bits_ready (bits_ready),
    .done       (done)
  );

  function automatic logic [3:0] exp_bits(input logic [15:0] d, input logic m, input int k);
    logic [3:0] r;
    logic [3:0] v;
    v = m ? stoch_seq[k] : 4'(k);
    for (int ch = 0; ch < 4; ch++) r[ch] = d[ch*4 +: 4] > v;
    return r;
  endfunction

  task automatic push_stream(input logic [15:0] d, input logic m);
    for (int k = 0; k < 16; k++) sb_q.push_back({(k == 15), exp_bits(d, m, k)});
  endtask

  // Called at a negedge; returns at the next negedge with load deasserted.
  task automatic start_load(input logic [15:0] d, input logic m);
    data_in    = d;
    mode       = m;
    load_valid = 1'b1;
    push_stream(d, m);
    @(negedge clk);
    load_valid = 1'b0;
    data_in    = ~d;
    mode       = ~m;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_valid = 1'b0; data_in = '0; mode = 1'b0; abort = 1'b0; bits_ready = 1'b1;
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_ready, bits_valid, done, bits_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b done=%b bits=%b, want all zero",
               load_ready, bits_valid, done, bits_out);
    end
    load_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || bits_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", load_ready, bits_valid);
    end
  endtask

  task automatic test_unary;
    int ones [4] = '{0, 0, 0, 0};
    int want_ones [4] = '{0, 5, 15, 8};
    int beats = 0;
    int guard = 0;
    logic [4:0] want;
    start_load(16'h8F50, 1'b0);
    while (sb_q.size() > 0 && guard < 40) begin
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want) begin
          errors++;
          $display("FAIL unary_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        for (int ch = 0; ch < 4; ch++) ones[ch] += int'(bits_out[ch]);
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL unary_timeout: got %0d beats, want 16", beats);
      sb_q.delete();
    end
    checks++;
    if (bits_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL unary_end: got vld=%b done=%b rdy=%b, want 0 0 1", bits_valid, done, load_ready);
    end
    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (ones[ch] != want_ones[ch]) begin
        errors++;
        $display("FAIL unary_ones_ch%0d: got %0d, want %0d", ch, ones[ch], want_ones[ch]);
      end
    end
  endtask

  // Stochastic stream of 8s followed immediately by a second set with mixed data.
  task automatic test_back_to_back;
    int ones [4] = '{0, 0, 0, 0};
    int beats = 0;
    int guard = 0;
    logic [4:0] want;
    start_load(16'h8888, 1'b1);
    checks++;
    if (bits_valid !== 1'b1) begin
      errors++;
      $display("FAIL stoch_first_latency: got vld=%b, want 1", bits_valid);
    end
    while (sb_q.size() > 0 && guard < 40) begin
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want || bits_out !== {4{bits_out[0]}}) begin
          errors++;
          $display("FAIL stoch8_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        for (int ch = 0; ch < 4; ch++) ones[ch] += int'(bits_out[ch]);
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (ones[ch] != 8) begin
        errors++;
        $display("FAIL stoch8_ones_ch%0d: got %0d, want 8", ch, ones[ch]);
      end
    end
    checks++;
    if (sb_q.size() != 0 || bits_valid !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bubble: got left=%0d vld=%b rdy=%b, want 0 0 1",
               sb_q.size(), bits_valid, load_ready);
      sb_q.delete();
    end
    start_load(16'hE1A3, 1'b1);
    checks++;
    if (bits_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_start: got vld=%b, want 1", bits_valid);
    end
    beats = 0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 40) begin
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want) begin
          errors++;
          $display("FAIL stochmix_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb_q.size() != 0 || bits_valid !== 1'b0) begin
      errors++;
      $display("FAIL stochmix_end: got left=%0d vld=%b, want 0 0", sb_q.size(), bits_valid);
      sb_q.delete();
    end
  endtask

  task automatic test_backpressure;
    int beats = 0;
    int guard = 0;
    int stall6 = 0;
    int stall15 = 0;
    logic [4:0] want;
    start_load(16'h7C93, 1'b0);
    while (sb_q.size() > 0 && guard < 60) begin
      bits_ready = 1'b1;
      if (bits_valid) begin
        want = sb_q[0];
        checks++;
        if ({done, bits_out} !== want) begin
          errors++;
          $display("FAIL stall_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        if (beats == 6 && stall6 < 3) begin
          bits_ready = 1'b0;
          stall6++;
        end else if (beats == 15 && stall15 < 2) begin
          bits_ready = 1'b0;
          stall15++;
        end else begin
          void'(sb_q.pop_front());
          beats++;
        end
      end
      @(negedge clk);
      guard++;
    end
    bits_ready = 1'b1;
    checks++;
    if (sb_q.size() != 0 || bits_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got left=%0d vld=%b done=%b, want 0 0 0", sb_q.size(), bits_valid, done);
      sb_q.delete();
    end
  endtask

  task automatic test_load_ignored;
    int beats = 0;
    int guard = 0;
    logic [4:0] want;
    start_load(16'h4A26, 1'b0);
    while (sb_q.size() > 0 && guard < 40) begin
      load_valid = 1'b0;
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want || load_ready !== 1'b0) begin
          errors++;
          $display("FAIL ignload_beat%0d: got done=%b bits=%b rdy=%b, want done=%b bits=%b rdy=0",
                   beats, done, bits_out, load_ready, want[4], want[3:0]);
        end
        if (beats == 4) begin
          load_valid = 1'b1;
          data_in    = 16'hFFFF;
          mode       = 1'b1;
        end
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    load_valid = 1'b0;
    checks++;
    if (sb_q.size() != 0 || bits_valid !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignload_end: got left=%0d vld=%b rdy=%b, want 0 0 1",
               sb_q.size(), bits_valid, load_ready);
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int beats = 0;
    int guard = 0;
    logic [4:0] want;
    start_load(16'h5B2D, 1'b1);
    while (beats < 9 && guard < 40) begin
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want) begin
          errors++;
          $display("FAIL rstmid_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bits_valid !== 1'b0 || bits_out !== 4'b0 || done !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flush: got vld=%b bits=%b done=%b rdy=%b, want all zero",
               bits_valid, bits_out, done, load_ready);
    end
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got rdy=%b, want 1", load_ready);
    end
    start_load(16'h5B2D, 1'b1);
    beats = 0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 40) begin
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want) begin
          errors++;
          $display("FAIL rstrestart_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rstrestart_timeout: got %0d beats, want 16", beats);
      sb_q.delete();
    end
  endtask

  task automatic test_abort;
    int beats = 0;
    int guard = 0;
    logic [4:0] want;
    start_load(16'h3F1A, 1'b0);
    while (beats < 3 && guard < 40) begin
      if (bits_valid) begin
        want = sb_q.pop_front();
        checks++;
        if ({done, bits_out} !== want) begin
          errors++;
          $display("FAIL abort_beat%0d: got done=%b bits=%b, want done=%b bits=%b",
                   beats, done, bits_out, want[4], want[3:0]);
        end
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    abort      = 1'b1;
    bits_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb_q.delete();
    checks++;
    if (bits_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_stop: got vld=%b done=%b rdy=%b, want 0 0 1", bits_valid, done, load_ready);
    end
    // abort while idle must not block a simultaneous load
    abort      = 1'b1;
    load_valid = 1'b1;
    data_in    = 16'h2222;
    mode       = 1'b0;
    @(negedge clk);
    abort      = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (bits_valid !== 1'b1 || done !== 1'b0 || bits_out !== exp_bits(16'h2222, 1'b0, 0)) begin
      errors++;
      $display("FAIL abort_idle_load: got vld=%b done=%b bits=%b, want 1 0 %b",
               bits_valid, done, bits_out, exp_bits(16'h2222, 1'b0, 0));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (bits_valid !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_second: got vld=%b rdy=%b, want 0 1", bits_valid, load_ready);
    end
  endtask

  initial begin
    test_reset();
    test_unary();
    test_back_to_back();
    test_backpressure();
    test_load_ignored();
    test_reset_mid();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
